// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the RISC-V core front end.
//   - XLEN      : datapath / PC width
//   - RESET_PC  : first fetch address after reset
//   - INSTR_NOP : canonical NOP (addi x0, x0, 0), shown on out_instr when idle
//   - DROP_W    : width of the "responses still to discard" counter in fetch
//   - fetch_pkt_t : {pc, instr} packet handed from IF to the IF/ID register
//   - sat_inc32 : saturating 32-bit increment used by optional perf counters
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  // Enough headroom for many back-to-back redirects over a slow memory;
  // the counter saturates rather than wrapping.
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO with registered storage. Used twice in the fetch
//   stage: as the in-order PC tag queue and as the {pc, instr} output buffer.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     push, push_data : write request / data
//     pop             : read request (ignored when empty)
//     flush           : discard all entries (wins over push/pop)
//     head_data       : oldest entry (valid when !empty)
//     count, full, empty : occupancy
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Effective push/pop: a pop frees the slot a same-cycle push may use.
  always_comb begin
    do_pop  = pop && (count_q != {CW{1'b0}});
    do_push = push && ((count_q != DEPTH_C) || do_pop);
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          mem_d[wr_ptr_q] = push_data;
          wr_ptr_d        = wr_ptr_q + AW'(1'b1);
          count_d         = count_q + CW'(1'b1);
        end
        2'b01: begin
          rd_ptr_d = rd_ptr_q + AW'(1'b1);
          count_d  = count_q - CW'(1'b1);
        end
        2'b11: begin
          mem_d[wr_ptr_q] = push_data;
          wr_ptr_d        = wr_ptr_q + AW'(1'b1);
          rd_ptr_d        = rd_ptr_q + AW'(1'b1);
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: {WIDTH{1'b0}}};
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == {CW{1'b0}});

  fetch_fifo_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (do_pop),
    .full (full)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// -----------------------------------------------------------------------------
// fetch_fifo_chk
//   Protocol checker bound into fetch_fifo: flags a push into a full FIFO
//   that is not relieved by a simultaneous pop (data would be lost).
//   Ports: clk, rst, push (requested push), pop (effective pop), full.
// -----------------------------------------------------------------------------
module fetch_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);

  // Overflow check, sampled on every active clock edge outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop))
        else $error("fetch_fifo overflow: push while full without pop");
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage: generates the PC, issues in-order requests to the
//   instruction memory, buffers responses and presents {pc, instr} to the
//   IF/ID register over a valid/ready handshake. A redirect flushes the stage
//   and restarts fetch at redirect_pc; responses to requests issued before
//   the redirect are counted and discarded as they come back.
//   Ports:
//     clk, rst                          : clock, synchronous active-high reset
//     imem_req_valid/ready/addr         : request channel (word aligned)
//     imem_rsp_valid/data               : in-order response channel
//     redirect_valid, redirect_pc       : flush and restart
//     out_valid/ready, out_pc, out_instr: IF/ID handshake (registered source)
//   Optional (macro FETCH_PERF_CNT_EN):
//     stall_cnt  : cycles with out_valid && !out_ready (saturating)
//     bubble_cnt : cycles with !out_valid && out_ready (saturating)
//   XLEN must match core_pkg::XLEN because the buffer uses fetch_pkt_t.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  import core_pkg::*;

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              run_q, run_d;

  logic [XLEN-1:0]   tag_head;
  logic [CW-1:0]     tag_count, buf_count;
  logic              tag_full, tag_empty, buf_full, buf_empty;
  fetch_pkt_t        buf_head, buf_wdata;

  logic              out_pop, rsp_drop, rsp_keep, tag_pop, buf_push;
  logic              req_valid, req_fire;
  logic [CW:0]       in_use;
  logic [DROP_W:0]   drop_sum;

  // Handshake qualifiers and issue credit. A pop this cycle frees a slot, so
  // the credit counts it to sustain one instruction per cycle.
  always_comb begin
    out_pop   = !buf_empty && out_ready;
    rsp_drop  = imem_rsp_valid && (drop_q != {DROP_W{1'b0}});
    rsp_keep  = imem_rsp_valid && (drop_q == {DROP_W{1'b0}});
    in_use    = {1'b0, tag_count} + {1'b0, buf_count} - {{CW{1'b0}}, out_pop};
    req_valid = run_q && !redirect_valid && !tag_full && (in_use < DEPTH_C);
    req_fire  = req_valid && imem_req_ready;
    // A response with no matching tag (e.g. stale after reset) is ignored.
    tag_pop   = rsp_keep && !tag_empty;
    buf_push  = rsp_keep && !tag_empty && !buf_full_blocked() && !redirect_valid;
    buf_wdata.pc    = tag_head;
    buf_wdata.instr = imem_rsp_data;
  end

  function automatic logic buf_full_blocked();
    return buf_full && !out_pop;
  endfunction

  // Next PC and discard counter; a redirect replaces both.
  always_comb begin
    pc_d     = pc_q;
    drop_d   = drop_q;
    run_d    = 1'b1;
    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(tag_count);
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // Every request not yet answered must now be discarded, except one
      // answered (and thrown away) in this very cycle.
      if (imem_rsp_valid && (drop_sum != {(DROP_W+1){1'b0}})) begin
        drop_sum = drop_sum - (DROP_W+1)'(1'b1);
      end else begin
        drop_sum = drop_sum;
      end
      if (drop_sum[DROP_W]) begin
        drop_d = {DROP_W{1'b1}};
      end else begin
        drop_d = drop_sum[DROP_W-1:0];
      end
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(3'd4);
      end else begin
        pc_d = pc_q;
      end
      if (rsp_drop) begin
        drop_d = drop_q - DROP_W'(1'b1);
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // PC, discard counter and issue-enable registers. run_q holds off issue
  // for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= {RESET_PC[XLEN-1:2], 2'b00};
      drop_q <= {DROP_W{1'b0}};
      run_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      run_q  <= run_d;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (tag_pop),
    .flush     (redirect_valid),
    .head_data (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_pkt_t)),
    .DEPTH (DEPTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (buf_wdata),
    .pop       (out_pop),
    .flush     (redirect_valid),
    .head_data (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;

  // Output view of the buffer head; only registered state feeds out_*.
  always_comb begin
    out_valid = !buf_empty;
    out_pc    = buf_head.pc;
    if (buf_empty) begin
      out_instr = INSTR_NOP;
    end else begin
      out_instr = buf_head.instr;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating stall / bubble event counters.
  always_comb begin
    if (!buf_empty && !out_ready) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (buf_empty && out_ready) begin
      bubble_cnt_d = sat_inc32(bubble_cnt_q);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= 32'h0000_0000;
      bubble_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A memory model with programmable latency
//   answers requests in order; a scoreboard predicts the delivered stream as
//   "consecutive word addresses from the last reset/redirect target", with
//   instr = mem_fn(pc), and checks it every cycle at the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;

  initial begin : memory
    logic        fire, took, rs;
    logic [31:0] faddr;
    mreq_t       tmp;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      fire  = (imem_req_valid === 1'b1) && imem_req_ready;
      faddr = imem_req_addr;
      took  = imem_rsp_valid;
      rs    = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (rs) begin
        mq.delete();
      end else begin
        if (took && mq.size() > 0) tmp = mq.pop_front();
        if (fire) mq.push_back('{addr: faddr, due: cyc + lat - 1});
      end
      if (!rs && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_fn(mq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [31:0] exp_pc, next_req, hold_pc, hold_instr;
  logic        prev_hold = 1'b0, prev_redir = 1'b0, prev_rst = 1'b0, started = 1'b0;
  int          pop_cnt = 0, fire_cnt = 0, stall_m = 0, bubble_m = 0;
  logic [31:0] pops[$];
  logic [31:0] instrs[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_pc     = 32'h0;
      next_req   = 32'h0;
      stall_m    = 0;
      bubble_m   = 0;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
      prev_rst   = 1'b1;
      started    = 1'b1;
    end else if (started) begin
      if (prev_rst) begin
        chk("post_reset_out_valid", 32'(out_valid), 32'h0);
        chk("post_reset_req_valid", 32'(imem_req_valid), 32'h0);
      end
      if (prev_redir) chk("post_redirect_out_valid", 32'(out_valid), 32'h0);
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'h1);
        chk("hold_pc", out_pc, hold_pc);
        chk("hold_instr", out_instr, hold_instr);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, 32'(stall_m));
      chk("bubble_cnt", bubble_cnt, 32'(bubble_m));
      if (out_valid && !out_ready) stall_m++;
      if (!out_valid && out_ready) bubble_m++;
`endif
      if (redirect_valid) chk("redirect_req_valid", 32'(imem_req_valid), 32'h0);
      if (imem_req_valid === 1'b1) begin
        chk("req_addr", imem_req_addr, next_req);
        if (imem_req_ready) begin
          next_req = next_req + 32'd4;
          fire_cnt++;
        end
      end
      if (out_valid && out_ready) begin
        chk("out_pc", out_pc, exp_pc);
        chk("out_instr", out_instr, mem_fn(exp_pc));
        pops.push_back(out_pc);
        instrs.push_back(out_instr);
        pop_cnt++;
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_pc   = {redirect_pc[31:2], 2'b00};
        next_req = {redirect_pc[31:2], 2'b00};
      end
      prev_hold  = out_valid && !out_ready && !redirect_valid;
      hold_pc    = out_pc;
      hold_instr = out_instr;
      prev_redir = redirect_valid;
      prev_rst   = 1'b0;
    end
  end

  task automatic wait_pops(input int n, input int budget, input string name);
    int target;
    target = pop_cnt + n;
    for (int i = 0; i < budget && pop_cnt < target; i++) step(1);
    total++;
    if (pop_cnt < target) begin
      bad++;
      $display("FAIL %s: pops=%0d required=%0d", name, pop_cnt, target);
    end
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step(1);
    redirect_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : main
    int  base, p0, f0;
    logic [31:0] s0;
    bit  hit;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    rst            = 1'b1;

    // 1. reset then streaming with 1-cycle memory
    lat = 1;
    step(2);
    rst  = 1'b0;
    base = pops.size();
    wait_pops(1, 20, "t1_first");
    p0 = pop_cnt;
    step(10);
    chk("t1_throughput", 32'(pop_cnt - p0), 32'd10);
    chk("t1_pc0", pops[base], 32'h0000_0000);
    chk("t1_pc1", pops[base+1], 32'h0000_0004);
    chk("t1_pc2", pops[base+2], 32'h0000_0008);
    chk("t1_instr0", instrs[base], 32'hC0DE_0013);

    // 2. backpressure: 5 stalled cycles
    out_ready = 1'b0;
    f0 = fire_cnt;
    step(5);
    chk("t2_req_bound", 32'(fire_cnt - f0 <= DEPTH), 32'h1);
    out_ready = 1'b1;
    wait_pops(6, 40, "t2_release");

    // 3. redirect with two requests in flight, 3-cycle memory
    lat = 3;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (mq.size() == 2 && !imem_rsp_valid) hit = 1'b1;
    end
    chk("t3_two_in_flight", 32'(hit), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step(1);
    redirect_valid = 1'b0;
    base = pops.size();
    wait_pops(2, 40, "t3_after");
    chk("t3_pc0", pops[base], 32'h0000_0100);
    chk("t3_pc1", pops[base+1], 32'h0000_0104);
    chk("t3_instr0", instrs[base], 32'hC0DE_0113);

    // 4. redirect coincident with a response and a pop
    lat = 1;
    wait_pops(3, 30, "t4_stream");
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (out_valid && imem_rsp_valid) hit = 1'b1;
    end
    chk("t4_coincide", 32'(hit), 32'h1);
    base = pops.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    step(1);
    redirect_valid = 1'b0;
    wait_pops(3, 30, "t4_after");
    chk("t4_pop_once", pops[base], pops[base-1] + 32'd4);
    chk("t4_pc_target", pops[base+1], 32'h0000_0200);
    chk("t4_pc_next", pops[base+2], 32'h0000_0204);

    // 5. reset mid-operation with buffered data and a pending request
    lat = 3;
    out_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step(1);
      if (out_valid && mq.size() > 0) hit = 1'b1;
    end
    chk("t5_setup", 32'(hit), 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    out_ready = 1'b1;
    base = pops.size();
    wait_pops(2, 40, "t5_restart");
    chk("t5_pc0", pops[base], 32'h0000_0000);
    chk("t5_pc1", pops[base+1], 32'h0000_0004);

    // 6. PC wrap
    lat = 1;
    redirect_to(32'hFFFF_FFFC);
    base = pops.size();
    wait_pops(3, 30, "t6_wrap");
    chk("t6_pc0", pops[base], 32'hFFFF_FFFC);
    chk("t6_pc1", pops[base+1], 32'h0000_0000);
    chk("t6_pc2", pops[base+2], 32'h0000_0004);

`ifdef FETCH_PERF_CNT_EN
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (out_valid) hit = 1'b1;
      else step(1);
    end
    chk("t6_perf_setup", 32'(hit), 32'h1);
    s0 = stall_cnt;
    out_ready = 1'b0;
    step(4);
    chk("t6_stall4", stall_cnt - s0, 32'd4);
    out_ready = 1'b1;
`else
    s0 = 32'h0;
`endif

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the pipelined RISC-V core.
- Generates the PC and issues in-order requests to the instruction memory.
- Buffers the responses and hands {pc, instr} to the IF/ID pipeline register through a valid/ready handshake.
- Absorbs decode stalls and flushes cleanly on a branch or jump redirect.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, combined limit on outstanding requests plus buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses are in order, latency ≥1 cycle.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  flush and restart from redirect_pc.
- redirect_pc  in  XLEN  new fetch address.
- out_valid  out  1  instruction available to the IF/ID register.
- out_ready  in  1  IF/ID register enable (the downstream stage is not stalled).
- out_pc  out  XLEN  PC of the presented instruction.
- out_instr  out  XLEN  presented instruction.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, outstanding=0, drop=0, FIFO empty.
  - imem_req_valid=0 and out_valid=0 in the cycle after the edge.
  - Reset wins over every other input, including in the middle of a transaction.
- Request issue:
  - imem_req_valid=1 whenever outstanding + fifo_count < DEPTH and redirect_valid=0.
  - imem_req_addr=pc.
  - On a handshake: pc += 4 (wraps modulo 2^XLEN), and the request PC is pushed into a PC tag queue.
- Response handling:
  - If drop>0: the response is discarded and drop decrements.
  - Otherwise {tag_pc, data} is pushed into the output FIFO.
  - The credit check guarantees the FIFO never overflows; an overflow is an assertion failure.
- Output:
  - out_valid = FIFO not empty; out_pc and out_instr come from the FIFO head.
  - Pop on out_valid && out_ready.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Latency:
  - Request to out_valid is memory latency + 1 cycle; the FIFO is registered.
  - No combinational path from imem_rsp_* to out_*.
- Redirect (single cycle):
  - pc <= redirect_pc; the FIFO is flushed.
  - drop <= drop + outstanding − (a response arriving this cycle ? 1 : 0).
  - The tag queue is cleared.
  - imem_req_valid is forced to 0 in the redirect cycle; issuing restarts the next cycle.
  - out_valid goes to 0 the cycle after.
- Simultaneous events:
  - Redirect and output pop in the same cycle: the pop is honoured, then the flush is applied.
  - Redirect and a response in the same cycle: the response is discarded.
  - Request and response in the same cycle: outstanding is unchanged.
- Steady state: throughput of 1 instruction/cycle when the memory sustains it and out_ready=1.
- Alignment: redirect_pc[1:0] is ignored; imem_req_addr[1:0] is always 0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, two extra outputs exist:
  - stall_cnt (32 bits): counts cycles with out_valid=1 && out_ready=0.
  - bubble_cnt (32 bits): counts cycles with out_valid=0 && out_ready=1.
  - Both counters clear on rst and saturate at all-ones.
- When undefined, neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - XLEN, RESET_PC and INSTR_NOP (32'h0000_0013).
  - A typedef for fetch_pkt_t {pc, instr}.
- The natural sub-module is fetch_fifo: a synchronous FIFO parameterised by width and depth with push, pop, flush, count, full and empty.
  - It is instantiated twice, once as the PC tag queue and once as the output buffer.

Test Plan:
1. Reset then streaming:
   - Stimulus: rst high 2 cycles, then 1-cycle memory, out_ready=1.
   - Response: out_pc sequence 0x0, 0x4, 0x8…, one per cycle after the first valid.
2. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles.
   - Response: at most DEPTH requests issued, out_pc/out_instr held stable, no loss, order preserved on release.
3. Redirect with 2 in flight:
   - Stimulus: 3-cycle memory latency, redirect_pc=0x100 while 2 requests are outstanding.
   - Response: both old responses dropped; the next out_pc is 0x100.
4. Redirect coincident with a response and a pop:
   - Response: the popped instruction is delivered once, the arriving response is discarded, and the next output is redirect_pc.
5. Reset mid-operation:
   - Stimulus: rst asserted with a full FIFO and an outstanding request.
   - Response: out_valid=0 next cycle, then fetch restarts at RESET_PC and the stale response is not forwarded if the memory is also reset.
6. PC wrap and optional counters:
   - Stimulus: redirect to 0xFFFF_FFFC.
   - Response: the next out_pc values are 0xFFFF_FFFC then 0x0.
   - With FETCH_PERF_CNT_EN defined, 4 stalled cycles give stall_cnt=4.
